// File: rtl/arrow_key_decoder.sv
// Arrow-key decoder: turns PS/2 scan-code bytes into held levels and press
// ticks for the extended left/right arrow keys. Every other code is dropped.
// An inter-byte timeout abandons partially received sequences.
module arrow_key_decoder #(
  parameter logic [7:0] LEFT_CODE      = 8'h6B,
  parameter logic [7:0] RIGHT_CODE     = 8'h74,
  parameter int         REPEAT_EN      = 0,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       left_key,
  output logic       right_key,
  output logic       left_tick,
  output logic       right_tick
);

  localparam logic [7:0] EXT_CODE = 8'hE0;
  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic REPEAT = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    EXT_BRK,
    BRK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             left_key_q, left_key_d;
  logic             right_key_q, right_key_d;
  logic             left_tick_q, left_tick_d;
  logic             right_tick_q, right_tick_d;

  // State, timeout counter and all outputs are registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      left_key_q   <= 1'b0;
      right_key_q  <= 1'b0;
      left_tick_q  <= 1'b0;
      right_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      left_key_q   <= left_key_d;
      right_key_q  <= right_key_d;
      left_tick_q  <= left_tick_d;
      right_tick_q <= right_tick_d;
    end
  end

  // Decode a received byte from the current state; otherwise run the
  // timeout. A byte arriving at expiry wins over the timeout.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    left_key_d   = left_key_q;
    right_key_d  = right_key_q;
    left_tick_d  = 1'b0;
    right_tick_d = 1'b0;

    if (rx_done_tick) begin
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (rx_data == EXT_CODE) begin
            state_d = EXT;
          end else if (rx_data == BRK_CODE) begin
            state_d = BRK;
          end else begin
            state_d = IDLE;
          end
        end
        EXT: begin
          state_d = IDLE;
          if (rx_data == BRK_CODE) begin
            state_d = EXT_BRK;
          end else if (rx_data == LEFT_CODE) begin
            left_tick_d = !left_key_q || REPEAT;
            left_key_d  = 1'b1;
          end else if (rx_data == RIGHT_CODE) begin
            right_tick_d = !right_key_q || REPEAT;
            right_key_d  = 1'b1;
          end else if (rx_data == EXT_CODE) begin
            state_d = EXT;
          end
        end
        EXT_BRK: begin
          state_d = IDLE;
          if (rx_data == LEFT_CODE) begin
            left_key_d = 1'b0;
          end else if (rx_data == RIGHT_CODE) begin
            right_key_d = 1'b0;
          end
        end
        BRK: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign left_key   = left_key_q;
  assign right_key  = right_key_q;
  assign left_tick  = left_tick_q;
  assign right_tick = right_tick_q;

endmodule
